// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: op codes and the
// carry/overflow pair carried from S1 to S2.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_ADC = 3'd5,
        OP_SLL = 3'd6,
        OP_SRL = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath.
// in: op, a, b, cin   out: result, carry, overflow
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [SHW-1:0] amt;
    logic           adc_cin;
    logic [WIDTH:0] add_s;
    logic [WIDTH:0] sub_s;
    logic [WIDTH:0] shl_s;
    logic [WIDTH:0] shr_s;
    logic           a_msb;
    logic           b_msb;

    assign amt     = b[SHW-1:0];
    assign adc_cin = (op == OP_ADC) && cin;
    assign a_msb   = a[WIDTH-1];
    assign b_msb   = b[WIDTH-1];

    assign add_s = {1'b0, a} + {1'b0, b}
                 + {{WIDTH{1'b0}}, adc_cin};
    // Bit WIDTH of the wide difference is the borrow.
    assign sub_s = {1'b0, a} - {1'b0, b};
    // Extra bit catches the last bit shifted out;
    // amount 0 leaves it at zero.
    assign shl_s = {1'b0, a} << amt;
    assign shr_s = {a, 1'b0} >> amt;

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                {carry, result} = add_s;
                overflow = (a_msb == b_msb)
                        && (add_s[WIDTH-1] != a_msb);
            end
            OP_SUB: begin
                {carry, result} = sub_s;
                overflow = (a_msb != b_msb)
                        && (sub_s[WIDTH-1] != a_msb);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLL: {carry, result} = shl_s;
            OP_SRL: {result, carry} = shr_s;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage pipelined ALU with valid/ready on both sides
// and an architectural carry flag for multi-word chaining.
// in:  clk, rst_n, in_valid, in_op, in_a, in_b,
//      carry_clr, out_ready
// out: in_ready, out_valid, out_result, out_carry,
//      out_zero, out_overflow, out_negative
module alu_pipe_param
    import alu_pipe_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             carry_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_negative
);

    logic             carry_q,      carry_d;
    logic             s1_valid_q,   s1_valid_d;
    logic [WIDTH-1:0] s1_result_q,  s1_result_d;
    alu_flags_t       s1_flags_q,   s1_flags_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_carry_q,  out_carry_d;
    logic             out_zero_q,   out_zero_d;
    logic             out_ovf_q,    out_ovf_d;
    logic             out_neg_q,    out_neg_d;

    logic             s2_can_load;
    logic             s2_load;
    logic             in_fire;
    logic             core_cin;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;

    assign s2_can_load = !out_valid_q || out_ready;
    assign s2_load     = s1_valid_q && s2_can_load;
    assign in_ready    = !s1_valid_q || s2_can_load;
    assign in_fire     = in_valid && in_ready;
    // carry_clr overrides the flag for this cycle's ADC.
    assign core_cin    = carry_q && !carry_clr;

    alu_pipe_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .op       (alu_op_t'(in_op)),
        .a        (in_a),
        .b        (in_b),
        .cin      (core_cin),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_ovf)
    );

    always_comb begin
        carry_d      = carry_q;
        s1_valid_d   = s1_valid_q;
        s1_result_d  = s1_result_q;
        s1_flags_d   = s1_flags_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_carry_d  = out_carry_q;
        out_zero_d   = out_zero_q;
        out_ovf_d    = out_ovf_q;
        out_neg_d    = out_neg_q;

        if (in_fire) begin
            carry_d = core_carry;
        end else if (carry_clr) begin
            carry_d = 1'b0;
        end

        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_result_d = core_result;
            s1_flags_d  = '{carry:    core_carry,
                            overflow: core_ovf};
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d  = 1'b1;
            out_result_d = s1_result_q;
            out_carry_d  = s1_flags_q.carry;
            out_ovf_d    = s1_flags_q.overflow;
            out_zero_d   = (s1_result_q == '0);
            out_neg_d    = s1_result_q[WIDTH-1];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_result_q  <= '0;
            s1_flags_q   <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_zero_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_neg_q    <= 1'b0;
        end else begin
            carry_q      <= carry_d;
            s1_valid_q   <= s1_valid_d;
            s1_result_q  <= s1_result_d;
            s1_flags_q   <= s1_flags_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_carry_q  <= out_carry_d;
            out_zero_q   <= out_zero_d;
            out_ovf_q    <= out_ovf_d;
            out_neg_q    <= out_neg_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_carry    = out_carry_q;
    assign out_zero     = out_zero_q;
    assign out_overflow = out_ovf_q;
    assign out_negative = out_neg_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Testbench for alu_pipe_param: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_alu_pipe_param;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [2:0]   in_op = '0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         carry_clr = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_zero;
    logic         out_overflow;
    logic         out_negative;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] r;
        logic        c, z, v, n;
    } exp_t;

    exp_t q[$];
    bit   mcarry = 1'b0;
    bit   acc;

    alu_pipe_param #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .carry_clr    (carry_clr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_negative (out_negative)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [15:0] a,
                                   input logic [15:0] b,
                                   input bit cin);
        exp_t e;
        int ia, ib, s, sa, sb, sv, amt;
        ia = a; ib = b;
        sa = $signed(a); sb = $signed(b);
        amt = ib % 16;
        e.c = 0; e.v = 0; s = 0; sv = 0;
        case (op)
            3'd0: begin
                s = ia + ib; e.c = (s > 65535);
                sv = sa + sb;
                e.v = (sv > 32767) || (sv < -32768);
            end
            3'd1: begin
                s = ia - ib; e.c = (ia < ib);
                sv = sa - sb;
                e.v = (sv > 32767) || (sv < -32768);
            end
            3'd2: s = ia & ib;
            3'd3: s = ia | ib;
            3'd4: s = ia ^ ib;
            3'd5: begin
                s = ia + ib + int'(cin); e.c = (s > 65535);
                sv = sa + sb + int'(cin);
                e.v = (sv > 32767) || (sv < -32768);
            end
            3'd6: begin
                s = ia << amt;
                e.c = (amt != 0) && s[16];
            end
            default: begin
                s = ia >> amt;
                e.c = (amt != 0) && (((ia >> (amt - 1)) & 1) == 1);
            end
        endcase
        e.r = s[15:0];
        e.z = (e.r == 16'h0);
        e.n = e.r[15];
        return e;
    endfunction

    function automatic logic [20:0] obs();
        return {out_valid, out_result, out_carry,
                out_zero, out_overflow, out_negative};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [2:0] op,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input bit clr, input bit ordy);
        exp_t e;
        in_valid = v; in_op = op; in_a = a; in_b = b;
        carry_clr = clr; out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e = model(op, a, b, clr ? 1'b0 : mcarry);
            q.push_back(e);
            mcarry = e.c;
        end else if (clr) begin
            mcarry = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 3'd0, 16'h0, 16'h0, 0, 1);
            step();
        end
        q.delete();
    endtask

    task automatic pair(input logic [2:0] op1,
                        input logic [15:0] a1, b1,
                        input bit c1,
                        input logic [2:0] op2,
                        input logic [15:0] a2, b2,
                        input bit c2,
                        output logic [20:0] o0, o1, o2, o3);
        drive(1, op1, a1, b1, c1, 1); step();
        drive(1, op2, a2, b2, c2, 1); o0 = obs(); step();
        drive(0, 3'd0, 16'h0, 16'h0, 0, 1); o1 = obs(); step();
        drive(0, 3'd0, 16'h0, 16'h0, 0, 1); o2 = obs(); step();
        drive(0, 3'd0, 16'h0, 16'h0, 0, 1); o3 = obs(); step();
    endtask

    task automatic test_reset();
        logic [20:0] o;
        rst_n = 0; in_valid = 0; out_ready = 0;
        #1;
        o = obs();
        checks++;
        if (o !== 21'h0) begin
            failures++;
            $display("FAIL reset_out: got %h want 0", o);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        step(); step();
        rst_n = 1;
        #1;
        o = obs();
        checks++;
        if (o !== 21'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: out %h rdy %b want 0/1",
                     o, in_ready);
        end
        mcarry = 0; q.delete();
        step();
    endtask

    task automatic test_carry_chain();
        logic [20:0] o0, o1, o2, o3;
        pair(3'd0, 16'hFFFF, 16'h0001, 0,
             3'd5, 16'h0000, 16'h0000, 0, o0, o1, o2, o3);
        checks++;
        if (o0[20] !== 1'b0) begin
            failures++;
            $display("FAIL chain_latency: valid %b want 0", o0[20]);
        end
        checks++;
        if (o1 !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL chain_add: got %h want %h", o1,
                     {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        if (o2 !== {1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL chain_adc: got %h want %h", o2,
                     {1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        checks++;
        if (o3[20] !== 1'b0) begin
            failures++;
            $display("FAIL chain_drain: valid %b want 0", o3[20]);
        end
        idle(2);
    endtask

    task automatic test_sub_ovf();
        logic [20:0] o0, o1, o2, o3;
        pair(3'd1, 16'h0001, 16'h0002, 0,
             3'd0, 16'h7FFF, 16'h0001, 0, o0, o1, o2, o3);
        checks++;
        if (o1 !== {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_borrow: got %h want %h", o1,
                     {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1});
        end
        checks++;
        if (o2 !== {1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL add_ovf: got %h want %h", o2,
                     {1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        idle(2);
    endtask

    task automatic test_shift();
        logic [20:0] o0, o1, o2, o3;
        pair(3'd6, 16'h8001, 16'h0011, 0,
             3'd7, 16'h0003, 16'h0000, 0, o0, o1, o2, o3);
        checks++;
        if (o1 !== {1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sll: got %h want %h", o1,
                     {1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        checks++;
        if (o2 !== {1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL srl0: got %h want %h", o2,
                     {1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        idle(2);
    endtask

    task automatic test_carry_clr();
        logic [20:0] o0, o1, o2, o3, o;
        pair(3'd0, 16'hFFFF, 16'h0001, 0,
             3'd5, 16'h0001, 16'h0001, 1, o0, o1, o2, o3);
        checks++;
        if (o2 !== {1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clr_adc: got %h want %h", o2,
                     {1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        idle(2);
        drive(1, 3'd0, 16'hFFFF, 16'h0001, 0, 1); step();
        drive(0, 3'd0, 16'h0, 16'h0, 1, 1); step();
        drive(1, 3'd5, 16'h0, 16'h0, 0, 1); step();
        drive(0, 3'd0, 16'h0, 16'h0, 0, 1); step();
        o = obs();
        checks++;
        if (o !== {1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clr_idle: got %h want %h", o,
                     {1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        logic [2:0]  ops [4];
        logic [15:0] as [4];
        logic [15:0] bs [4];
        logic [20:0] snap, o;
        exp_t e;
        int idx, got;
        bit first;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            as[i]  = 16'($urandom);
            bs[i]  = 16'($urandom);
        end
        idx = 0; snap = '0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4)
                drive(1, ops[idx], as[idx], bs[idx], 0, 0);
            else
                drive(0, 3'd0, 16'h0, 16'h0, 0, 0);
            if (acc) idx++;
            if (c == 2) snap = obs();
            if (c == 4) begin
                o = obs();
                checks++;
                if (idx !== 2 || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_stall: accepts %0d rdy %b want 2/0",
                             idx, in_ready);
                end
                checks++;
                if (o !== snap || o[20] !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold: got %h want %h", o, snap);
                end
            end
            step();
        end
        got = 0; first = 1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (idx < 4)
                drive(1, ops[idx], as[idx], bs[idx], 0, 1);
            else
                drive(0, 3'd0, 16'h0, 16'h0, 0, 1);
            if (acc) idx++;
            if (first) begin
                first = 0;
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_release: rdy %b want 1", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                o = obs();
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra: result %h unexpected",
                             out_result);
                end else begin
                    e = q.pop_front();
                    if (o[19:0] !== {e.r, e.c, e.z, e.v, e.n}) begin
                        failures++;
                        $display("FAIL bp_order: got %h want %h",
                                 o[19:0], {e.r, e.c, e.z, e.v, e.n});
                    end
                end
                got++;
            end
            step();
        end
        checks++;
        if (got !== 4) begin
            failures++;
            $display("FAIL bp_count: got %0d results want 4", got);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [20:0] o;
        exp_t e;
        int got;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            drive(c < 8, 3'($urandom_range(0, 7)), 16'($urandom),
                  16'($urandom), 0, 1);
            if (c < 8) begin
                checks++;
                if (!acc) begin
                    failures++;
                    $display("FAIL b2b_accept: cycle %0d rdy %b want 1",
                             c, in_ready);
                end
            end
            if (c >= 2 && c < 10) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_valid: cycle %0d valid %b want 1",
                             c, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                o = obs();
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: result %h unexpected",
                             out_result);
                end else begin
                    e = q.pop_front();
                    if (o[19:0] !== {e.r, e.c, e.z, e.v, e.n}) begin
                        failures++;
                        $display("FAIL b2b_data: got %h want %h",
                                 o[19:0], {e.r, e.c, e.z, e.v, e.n});
                    end
                end
                got++;
            end
            step();
        end
        checks++;
        if (got !== 8) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 8", got);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [20:0] o;
        drive(1, 3'd0, 16'hFFFF, 16'h0001, 0, 0); step();
        drive(1, 3'd0, 16'hFFFF, 16'h0002, 0, 0); step();
        in_valid = 0; out_ready = 0;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid: valid %b rdy %b want 0/1",
                     out_valid, in_ready);
        end
        q.delete(); mcarry = 0;
        step();
        rst_n = 1;
        drive(1, 3'd5, 16'h0005, 16'h0006, 0, 1); step();
        drive(0, 3'd0, 16'h0, 16'h0, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush: valid %b want 0", out_valid);
        end
        step();
        drive(0, 3'd0, 16'h0, 16'h0, 0, 1);
        o = obs();
        checks++;
        if (o !== {1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rst_first: got %h want %h", o,
                     {1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        step();
        idle(2);
    endtask

    task automatic test_random();
        logic [20:0] o, prev;
        exp_t e;
        bit hold;
        hold = 0; prev = '0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)),
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7);
            o = obs();
            if (hold) begin
                checks++;
                if (o !== prev) begin
                    failures++;
                    $display("FAIL rnd_hold: got %h want %h", o, prev);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra: result %h unexpected",
                             out_result);
                end else begin
                    e = q.pop_front();
                    if (o[19:0] !== {e.r, e.c, e.z, e.v, e.n}) begin
                        failures++;
                        $display("FAIL rnd_data: got %h want %h",
                                 o[19:0], {e.r, e.c, e.z, e.v, e.n});
                    end
                end
            end
            hold = out_valid && !out_ready;
            prev = o;
            step();
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            drive(0, 3'd0, 16'h0, 16'h0, 0, 1);
            if (out_valid) begin
                o = obs();
                e = q.pop_front();
                checks++;
                if (o[19:0] !== {e.r, e.c, e.z, e.v, e.n}) begin
                    failures++;
                    $display("FAIL rnd_drain: got %h want %h",
                             o[19:0], {e.r, e.c, e.z, e.v, e.n});
                end
            end
            step();
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rnd_lost: %0d results missing want 0",
                     q.size());
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_sub_ovf();
        test_shift();
        test_carry_clr();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
